uart_tx_drain: RTL and testbench

Serial transmitter that drains the 8-bit sample FIFO and shifts each byte out as an asynchronous UART frame (start, 8 data LSB-first, optional parity, stop). Sits directly downstream of the FIFO, driving its read strobe and consuming its data and empty flag. It absorbs the FIFO's one-cycle lag between the empty flag falling and the data output becoming valid.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_tx_drain.sv | 116 +++++++++++
 tb/tb_uart_tx_drain.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Parity bit to transmit for a byte; meaningless when parity is disabled.
    function automatic logic parity_of(input logic [7:0] b, input int mode);
        return (mode == PAR_ODD) ? ~^b : ^b;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable bit-period down-counter with end-of-bit tick
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic sys_clock,
    input  logic reset,
    input  logic load,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Reloads on its own at each bit boundary so consecutive bits need no extra load.
    always_ff @(posedge sys_clock) begin
        if (reset || load || (count == '0)) begin
            count <= RELOAD;
        end else begin
            count <= count - CW'(1);
        end
    end

    assign bit_tick = (count == '0);

endmodule

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - FIFO-draining UART transmitter with optional parity
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_en,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    import uart_pkg::*;

    state_t     state;
    state_t     next_state;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;
    logic       stop_cnt;
    logic       par_bit;
    logic       bit_tick;
    logic       timer_load;
    logic       last_stop;

    assign timer_load = (state == ST_IDLE) || (state == ST_SETTLE);
    assign last_stop  = (stop_cnt == 1'(STOP_BITS - 1));

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .sys_clock(sys_clock),
        .reset    (reset),
        .load     (timer_load),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        byte_done  = 1'b0;
        case (state)
            ST_IDLE:   if (tx_enable && !fifo_empty) next_state = ST_SETTLE;
            ST_SETTLE: next_state = ST_START;
            ST_START:  if (bit_tick) next_state = ST_DATA;
            ST_DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) begin
                    next_state = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (bit_tick) next_state = ST_STOP;
            ST_STOP: begin
                if (bit_tick && last_stop) begin
                    next_state = ST_IDLE;
                    byte_done  = 1'b1;
                end
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    // SETTLE is the first cycle fifo_data is valid; latch it and pop in one step.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            shift_reg    <= '0;
            bit_idx      <= '0;
            stop_cnt     <= 1'b0;
            par_bit      <= 1'b0;
            fifo_read_en <= 1'b0;
        end else begin
            fifo_read_en <= (state == ST_SETTLE);
            case (state)
                ST_SETTLE: begin
                    shift_reg <= fifo_data;
                    par_bit   <= parity_of(fifo_data, PARITY);
                    bit_idx   <= '0;
                    stop_cnt  <= 1'b0;
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) stop_cnt <= stop_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_reg[0];
            ST_PARITY: tx = par_bit;
            default:   tx = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - scoreboard bench for uart_tx_drain
module tb_uart_tx_drain;

    localparam int CPB  = 4;
    localparam int LEN0 = 10 * CPB;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_read_en;
    logic       tx;
    logic       busy;
    logic       byte_done;

    logic       pe_empty, po_empty;
    logic [7:0] pe_data, po_data;
    logic       pe_rd, po_rd, pe_tx, po_tx, pe_busy, po_busy, pe_done, po_done;

    always #5 sys_clock = ~sys_clock;

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(0)) dut (
        .sys_clock(sys_clock), .reset(reset), .tx_enable(tx_enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
        .tx(tx), .busy(busy), .byte_done(byte_done)
    );

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(2)) dut_even (
        .sys_clock(sys_clock), .reset(reset), .tx_enable(tx_enable),
        .fifo_empty(pe_empty), .fifo_data(pe_data), .fifo_read_en(pe_rd),
        .tx(pe_tx), .busy(pe_busy), .byte_done(pe_done)
    );

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY(1)) dut_odd (
        .sys_clock(sys_clock), .reset(reset), .tx_enable(tx_enable),
        .fifo_empty(po_empty), .fifo_data(po_data), .fifo_read_en(po_rd),
        .tx(po_tx), .busy(po_busy), .byte_done(po_done)
    );

    // FIFO model: data output lags the head by one clock.
    logic [7:0] fmem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge sys_clock) begin
        cyc <= cyc + 1;
        fifo_data <= fmem[rd_ptr[3:0]];
        if (fifo_read_en && !fifo_empty) rd_ptr <= rd_ptr + 1;
    end

    typedef struct {
        logic [7:0] b;
        int         start;
        bit         ok;
        bit         done_ok;
    } frame_t;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int rd_count = 0, done_count = 0, dbl_strobe = 0;
    logic prev_rd = 1'b0;

    bit         dec_active = 1'b0;
    int         dec_start, off, slot;
    logic [7:0] dec_byte;
    bit         dec_ok;
    logic       bit_val, want;

    // Frame decoder on the main DUT line; every cycle of every bit must hold its value.
    always @(negedge sys_clock) begin
        if (fifo_read_en === 1'b1) begin
            rd_count++;
            if (prev_rd === 1'b1) dbl_strobe++;
        end
        prev_rd = fifo_read_en;
        if (byte_done === 1'b1) done_count++;
        if (reset !== 1'b0) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (tx === 1'b0) begin
                dec_active = 1'b1;
                dec_start  = cyc;
                dec_ok     = 1'b1;
                dec_byte   = 8'h00;
                bit_val    = 1'b0;
            end
        end else begin
            off  = cyc - dec_start;
            slot = off / CPB;
            if ((off % CPB == 0) && slot >= 1 && slot <= 8) begin
                bit_val = tx;
                dec_byte[slot-1] = tx;
            end
            want = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : bit_val;
            if ($isunknown(tx) || tx !== want) dec_ok = 1'b0;
            if (off == LEN0 - 1) begin
                rx_q.push_back('{dec_byte, dec_start, dec_ok, byte_done === 1'b1});
                dec_active = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit expect_out);
        fmem[wr_ptr[3:0]] = b;
        wr_ptr++;
        if (expect_out) exp_q.push_back(b);
    endtask

    task automatic get_frame(output frame_t f, output logic [7:0] exp_b);
        int t = 0;
        while (rx_q.size() == 0 && t < 200) begin
            @(negedge sys_clock);
            t++;
        end
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (rx_q.size() > 0) f = rx_q.pop_front();
        else f = '{8'hxx, -1, 1'b0, 1'b0};
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_enable = 1'b0;
        pe_empty = 1'b1; po_empty = 1'b1; pe_data = 8'h00; po_data = 8'h00;
        repeat (3) @(posedge sys_clock);
        @(negedge sys_clock);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (fifo_read_en !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", fifo_read_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (byte_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", byte_done); end
        @(posedge sys_clock); #1 reset = 1'b0; tx_enable = 1'b1;
    endtask

    task automatic test_single();
        frame_t f; logic [7:0] e; int n, rd0;
        @(posedge sys_clock); #1;
        n = cyc; rd0 = rd_count;
        push_byte(8'hA5, 1'b1);
        @(negedge sys_clock);
        @(negedge sys_clock);
        checks++; if ({busy, tx, fifo_read_en} !== 3'b110) begin errors++; $display("FAIL settle_cycle got %b want 110", {busy, tx, fifo_read_en}); end
        @(negedge sys_clock);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL start_tx got %b want 0", tx); end
        checks++; if (fifo_read_en !== 1'b1) begin errors++; $display("FAIL strobe_n2 got %b want 1", fifo_read_en); end
        @(negedge sys_clock);
        checks++; if (fifo_read_en !== 1'b0) begin errors++; $display("FAIL strobe_n3 got %b want 0", fifo_read_en); end
        get_frame(f, e);
        checks++; if (f.b !== e) begin errors++; $display("FAIL single_byte got %h want %h", f.b, e); end
        checks++; if (!f.ok) begin errors++; $display("FAIL single_format got %b want 1", f.ok); end
        checks++; if (f.start != n + 2) begin errors++; $display("FAIL single_start got %0d want %0d", f.start, n + 2); end
        checks++; if (!f.done_ok) begin errors++; $display("FAIL single_done got %b want 1", f.done_ok); end
        repeat (3) @(negedge sys_clock);
        checks++; if (rd_count - rd0 != 1) begin errors++; $display("FAIL single_strobes got %0d want 1", rd_count - rd0); end
    endtask

    task automatic test_back_to_back();
        frame_t f[3]; logic [7:0] e; int rd0, d0;
        @(posedge sys_clock); #1;
        rd0 = rd_count; d0 = done_count;
        push_byte(8'h00, 1'b1); push_byte(8'hFF, 1'b1); push_byte(8'h3C, 1'b1);
        for (int i = 0; i < 3; i++) begin
            get_frame(f[i], e);
            checks++; if (f[i].b !== e || !f[i].ok) begin errors++; $display("FAIL b2b_byte%0d got %h ok=%b want %h", i, f[i].b, f[i].ok, e); end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (f[i+1].start - f[i].start != LEN0 + 2) begin
                errors++; $display("FAIL b2b_gap%0d got %0d want %0d", i, f[i+1].start - f[i].start, LEN0 + 2);
            end
        end
        repeat (5) @(negedge sys_clock);
        checks++; if (rd_count - rd0 != 3) begin errors++; $display("FAIL b2b_strobes got %0d want 3", rd_count - rd0); end
        checks++; if (done_count - d0 != 3) begin errors++; $display("FAIL b2b_done got %0d want 3", done_count - d0); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", fifo_empty); end
    endtask

    task automatic test_enable_gate();
        frame_t f; logic [7:0] e; int m, rd0, low_seen;
        @(posedge sys_clock); #1;
        tx_enable = 1'b0; rd0 = rd_count; low_seen = 0;
        push_byte(8'h5A, 1'b1);
        repeat (100) begin
            @(negedge sys_clock);
            if (tx !== 1'b1) low_seen++;
        end
        checks++; if (low_seen != 0) begin errors++; $display("FAIL gate_tx_low got %0d want 0", low_seen); end
        checks++; if (rd_count != rd0) begin errors++; $display("FAIL gate_strobe got %0d want 0", rd_count - rd0); end
        @(posedge sys_clock); #1;
        tx_enable = 1'b1; m = cyc;
        get_frame(f, e);
        checks++; if (f.b !== e) begin errors++; $display("FAIL gate_byte got %h want %h", f.b, e); end
        checks++; if (f.start != m + 2) begin errors++; $display("FAIL gate_start got %0d want %0d", f.start, m + 2); end
    endtask

    task automatic test_enable_drop();
        frame_t f; logic [7:0] e; int n, rd0, low_seen;
        @(posedge sys_clock); #1;
        n = cyc; rd0 = rd_count; low_seen = 0;
        push_byte(8'h55, 1'b1); push_byte(8'h66, 1'b1);
        do begin @(posedge sys_clock); #1; end while (cyc < n + 14);
        tx_enable = 1'b0;
        get_frame(f, e);
        checks++; if (f.b !== e || !f.ok) begin errors++; $display("FAIL drop_byte got %h ok=%b want %h", f.b, f.ok, e); end
        repeat (60) begin
            @(negedge sys_clock);
            if (tx !== 1'b1) low_seen++;
        end
        checks++; if (low_seen != 0) begin errors++; $display("FAIL drop_no_next got %0d want 0", low_seen); end
        checks++; if (rd_count - rd0 != 1) begin errors++; $display("FAIL drop_strobes got %0d want 1", rd_count - rd0); end
        @(posedge sys_clock); #1 tx_enable = 1'b1;
        get_frame(f, e);
        checks++; if (f.b !== e) begin errors++; $display("FAIL drop_resume got %h want %h", f.b, e); end
    endtask

    task automatic test_reset_midframe();
        frame_t f; logic [7:0] e; int n, rd0;
        @(posedge sys_clock); #1;
        n = cyc; rd0 = rd_count;
        push_byte(8'h81, 1'b0); push_byte(8'h42, 1'b1);
        do begin @(posedge sys_clock); #1; end while (cyc < n + 2 + 17);
        reset = 1'b1;
        @(posedge sys_clock);
        @(negedge sys_clock);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (fifo_read_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rd got %b want 0", fifo_read_en); end
        @(posedge sys_clock); #1 reset = 1'b0;
        get_frame(f, e);
        checks++; if (f.b !== e || !f.ok) begin errors++; $display("FAIL rst_mid_next got %h ok=%b want %h", f.b, f.ok, e); end
        repeat (60) @(negedge sys_clock);
        checks++; if (rx_q.size() != 0 || rd_count - rd0 != 2) begin
            errors++; $display("FAIL rst_mid_resend got frames=%0d strobes=%0d want 0 2", rx_q.size(), rd_count - rd0);
        end
    endtask

    task automatic run_parity(input bit odd, input logic [7:0] b, input logic exp_par);
        int n; logic ptx, bd42, bd43, b1, r2, t2;
        @(posedge sys_clock); #1;
        if (odd) begin po_data = b; po_empty = 1'b0; end
        else begin pe_data = b; pe_empty = 1'b0; end
        n = cyc;
        @(posedge sys_clock); #1;
        po_empty = 1'b1; pe_empty = 1'b1;
        @(negedge sys_clock);
        b1 = odd ? po_busy : pe_busy;
        @(negedge sys_clock);
        r2 = odd ? po_rd : pe_rd;
        t2 = odd ? po_tx : pe_tx;
        checks++; if ({b1, r2, t2} !== 3'b110) begin errors++; $display("FAIL par_start odd=%0d got %b want 110", odd, {b1, r2, t2}); end
        do @(negedge sys_clock); while (cyc < n + 2 + 38);
        ptx = odd ? po_tx : pe_tx;
        checks++; if (ptx !== exp_par) begin errors++; $display("FAIL par_bit odd=%0d byte=%h got %b want %b", odd, b, ptx, exp_par); end
        do @(negedge sys_clock); while (cyc < n + 2 + 42);
        bd42 = odd ? po_done : pe_done;
        @(negedge sys_clock);
        bd43 = odd ? po_done : pe_done;
        checks++; if ({bd42, bd43} !== 2'b01) begin errors++; $display("FAIL par_len odd=%0d got %b want 01", odd, {bd42, bd43}); end
        repeat (4) @(negedge sys_clock);
    endtask

    initial begin
        reset = 1'b1; tx_enable = 1'b0;
        pe_empty = 1'b1; po_empty = 1'b1; pe_data = 8'h00; po_data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_gate();
        test_enable_drop();
        run_parity(1'b0, 8'hA5, 1'b0);
        run_parity(1'b1, 8'h01, 1'b0);
        run_parity(1'b0, 8'h01, 1'b1);
        test_reset_midframe();
        checks++; if (dbl_strobe != 0) begin errors++; $display("FAIL strobe_double got %0d want 0", dbl_strobe); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
